// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate-extension unit with valid/ready handshake and a
// two-entry (main + skid) output buffer so one result per cycle is sustained under
// back-pressure.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is registered, low only when FULL)
//   in_imm [IN_W]         raw immediate field
//   in_mode [2]           00 SEXT, 01 ZEXT, 10 UPPER, 11 BRANCH
//   out_valid / out_ready output handshake
//   out_data [OUT_W]      extended operand
//   out_mode [2]          mode that produced out_data
//   out_count [CNT_W]     wrapping count of delivered results
module imm_ext_pipe #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned BR_SHIFT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [OUT_W-1:0]   main_data_q, main_data_d;
  logic [1:0]         main_mode_q, main_mode_d;
  logic [OUT_W-1:0]   skid_data_q, skid_data_d;
  logic [1:0]         skid_mode_q, skid_mode_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [OUT_W-1:0]   ext_sext;
  logic [OUT_W-1:0]   ext_val;
  logic               in_fire;
  logic               out_fire;

  // Combinational extension of the presented immediate.
  always_comb begin
    // Size cast of a signed operand replicates the sign bit.
    ext_sext = OUT_W'($signed(in_imm));
    case (in_mode)
      2'b00:   ext_val = ext_sext;
      2'b01:   ext_val = OUT_W'(in_imm);
      2'b10:   ext_val = OUT_W'(in_imm) << (OUT_W - IN_W);
      default: ext_val = ext_sext << BR_SHIFT;
    endcase
  end

  assign out_valid = (state_q == StOne) || (state_q == StFull);
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_mode_d = main_mode_q;
    skid_data_d = skid_data_q;
    skid_mode_d = skid_mode_q;
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_data_d = ext_val;
          main_mode_d = in_mode;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_data_d = ext_val;
          main_mode_d = in_mode;
        end else if (in_fire) begin
          skid_data_d = ext_val;
          skid_mode_d = in_mode;
          state_d     = StFull;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_fire) begin
          main_data_d = skid_data_q;
          main_mode_d = skid_mode_q;
          state_d     = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Registered ready: reflects the state being entered, never out_ready directly.
    in_ready_d = (state_d != StFull);
    count_d    = out_fire ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_mode_q <= '0;
      skid_data_q <= '0;
      skid_mode_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_mode_q <= main_mode_d;
      skid_data_q <= skid_data_d;
      skid_mode_q <= skid_mode_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign out_mode  = main_mode_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: vector table for the extension modes,
// scoreboard queue for ordering, and hand-written back-pressure, throughput,
// counter-wrap and mid-stream reset sequences.
module tb_imm_ext_pipe;

  localparam int unsigned CntW = 4;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_imm;
  logic [1:0]      in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic [1:0]      out_mode;
  logic [CntW-1:0] out_count;

  imm_ext_pipe #(
    .IN_W    (16),
    .OUT_W   (32),
    .BR_SHIFT(2),
    .CNT_W   (CntW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mode (out_mode),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[10];
  int          checks;
  int          errors;
  int          pops;
  int          full_cycles;
  int          cyc;
  int          pop_cyc[$];
  logic [33:0] sb[$];
  logic [31:0] cur_exp;
  logic        stall_prev;
  logic [33:0] stall_word;

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] s;
    s = {{16{imm[15]}}, imm};
    case (mode)
      2'b00:   return s;
      2'b01:   return {16'h0000, imm};
      2'b10:   return {imm, 16'h0000};
      default: return {s[29:0], 2'b00};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard step, sampled on the falling edge (between active edges).
  task automatic monitor_step();
    logic [33:0] e;
    cyc++;
    if (!rst_n) begin
      stall_prev = 1'b0;
      sb.delete();
    end else begin
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_word", 64'({out_mode, out_data}), 64'(stall_word));
      end
      if (!in_ready) full_cycles++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected nothing", {out_mode, out_data});
        end else begin
          e = sb.pop_front();
          check("out_word", 64'({out_mode, out_data}), 64'(e));
          pops++;
          pop_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) sb.push_back({in_mode, cur_exp});
      stall_prev = out_valid && !out_ready;
      stall_word = {out_mode, out_data};
    end
  endtask

  // Present one item and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic drive(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    cur_exp  = exp;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_mode"}, 64'(out_mode), 64'd0);
    check({tag, "_out_count"}, 64'(out_count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int pbase;
    logic [15:0] imm;
    checks      = 0;
    errors      = 0;
    pops        = 0;
    full_cycles = 0;
    cyc         = 0;
    stall_prev  = 1'b0;
    stall_word  = '0;
    cur_exp     = '0;
    in_valid    = 1'b0;
    in_imm      = '0;
    in_mode     = '0;
    out_ready   = 1'b1;
    rst_n       = 1'b1;

    vecs[0] = '{16'h8001, 2'b00, 32'hFFFF8001};
    vecs[1] = '{16'h8001, 2'b01, 32'h00008001};
    vecs[2] = '{16'h0001, 2'b00, 32'h00000001};
    vecs[3] = '{16'h1234, 2'b10, 32'h12340000};
    vecs[4] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};
    vecs[5] = '{16'h0003, 2'b11, 32'h0000000C};
    vecs[6] = '{16'h7FFF, 2'b00, 32'h00007FFF};
    vecs[7] = '{16'hFFFF, 2'b01, 32'h0000FFFF};
    vecs[8] = '{16'h8000, 2'b10, 32'h80000000};
    vecs[9] = '{16'h8000, 2'b11, 32'hFFFE0000};

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    @(posedge clk);
    #1;
    do_reset("rst0");

    // Extension table, one cycle latency, out_ready held high.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].imm, vecs[i].mode, vecs[i].exp);
      check("lat_valid", 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].exp));
      check($sformatf("vec%0d_mode", i), 64'(out_mode), 64'(vecs[i].mode));
    end
    drain();
    check("table_count", 64'(out_count), 64'd10);

    // Back-pressure: A,B absorbed, C held off until out_ready rises.
    do_reset("rst1");
    out_ready = 1'b0;
    pbase = pops;
    drive(16'h000A, 2'b00, ref_ext(16'h000A, 2'b00));
    check("bp_ready_after_a", 64'(in_ready), 64'd1);
    drive(16'h800B, 2'b11, ref_ext(16'h800B, 2'b11));
    check("bp_ready_after_b", 64'(in_ready), 64'd0);
    fork
      begin
        drive(16'hC00C, 2'b10, ref_ext(16'hC00C, 2'b10));
        drive(16'hD00D, 2'b01, ref_ext(16'hD00D, 2'b01));
      end
      begin
        repeat (3) begin
          @(posedge clk);
          #2;
          check("bp_c_held", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_pops", 64'(pops - pbase), 64'd4);
    check("bp_count", 64'(out_count), 64'd4);

    // Simultaneous fire in ONE: 10 back-to-back results, never FULL.
    do_reset("rst2");
    base  = full_cycles;
    pbase = pops;
    for (int i = 0; i < 10; i++) begin
      imm = 16'(32'h1111 * i + 32'h8000);
      drive(imm, 2'(i), ref_ext(imm, 2'(i)));
    end
    drain();
    check("tp_pops", 64'(pops - pbase), 64'd10);
    check("tp_never_full", 64'(full_cycles - base), 64'd0);
    check("tp_consecutive", 64'(pop_cyc[pbase + 9] - pop_cyc[pbase]), 64'd9);
    check("tp_count", 64'(out_count), 64'd10);

    // Counter wrap at CNT_W=4: 17 fires leave out_count at 1.
    do_reset("rst3");
    for (int i = 0; i < 17; i++) begin
      imm = 16'($urandom);
      drive(imm, 2'(i % 4), ref_ext(imm, 2'(i % 4)));
    end
    drain();
    check("wrap_count", 64'(out_count), 64'd1);

    // Asynchronous reset while FULL; skid contents must not reappear.
    do_reset("rst4");
    out_ready = 1'b0;
    drive(16'h1111, 2'b00, ref_ext(16'h1111, 2'b00));
    drive(16'h2222, 2'b01, ref_ext(16'h2222, 2'b01));
    check("mid_full", 64'(in_ready), 64'd0);
    do_reset("rst_mid");
    out_ready = 1'b1;
    pbase = pops;
    drive(16'hF00D, 2'b11, ref_ext(16'hF00D, 2'b11));
    check("mid_first_data", 64'(out_data), 64'(ref_ext(16'hF00D, 2'b11)));
    drain();
    check("mid_pops", 64'(pops - pbase), 64'd1);
    check("mid_count", 64'(out_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
